// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and BTB-update entry layout for branch_redirect_ctrl.
// Entry layout, MSB to LSB: {pc, target, taken}.
package branch_redirect_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } brc_state_e;

    localparam int unsigned TAKEN_OFS  = 0;
    localparam int unsigned TARGET_OFS = 1;

    function automatic int unsigned btb_entry_w(input int unsigned xlen);
        return 2 * xlen + 1;
    endfunction

    function automatic int unsigned pc_ofs(input int unsigned xlen);
        return xlen + 1;
    endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Synchronous FIFO holding BTB training updates; head is read straight from
// storage registers, so a push becomes visible on the following cycle.
module btb_update_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW:0]                 wr_q, rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            // Push into a full FIFO is only legal alongside a pop; the slot
            // being overwritten is the one draining this cycle.
            if (push_i) begin
                mem_q[wr_q[AW-1:0]] <= push_data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolution: one-cycle redirect/flush on mispredict and
// queued BTB training updates. Optional counters behind BRANCH_PERF_EN.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned XLEN   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_update_btb,
    input  logic            ex_modify_pc,
    input  logic            ex_predicted_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_update_pc,
    input  logic [XLEN-1:0] ex_jump_addr,
    input  logic            stall_in,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            stall_out,
    output logic            btb_wr_valid,
    input  logic            btb_wr_ready,
    output logic [XLEN-1:0] btb_wr_pc,
    output logic [XLEN-1:0] btb_wr_target,
    output logic            btb_wr_taken
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts,
    output logic [31:0]     perf_q_stalls
`endif
);
    localparam int unsigned EW     = btb_entry_w(XLEN);
    localparam int unsigned PC_OFS = pc_ofs(XLEN);

    brc_state_e      state_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [EW-1:0]   push_data, head;
    logic            full, empty, push, pop, accept, in_run;

    assign in_run    = (state_q == RUN);
    assign pop       = btb_wr_valid & btb_wr_ready;
    assign stall_out = full & !pop & ex_valid & ex_update_btb & in_run;
    assign accept    = ex_valid & in_run & !stall_in & !stall_out;
    assign push      = accept & ex_update_btb;
    assign push_data = {ex_pc, ex_jump_addr, ex_modify_pc ^ ex_predicted_taken};

    btb_update_fifo #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    // REDIRECT always falls back to RUN; its EX contents are wrong-path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            redirect_pc_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept && ex_modify_pc) begin
                        state_q       <= REDIRECT;
                        redirect_pc_q <= ex_update_pc;
                    end
                end
                REDIRECT: state_q <= RUN;
                default:  state_q <= RUN;
            endcase
        end
    end

    assign redirect_valid = (state_q == REDIRECT);
    assign flush_if_id    = (state_q == REDIRECT);
    assign flush_id_ex    = (state_q == REDIRECT);
    assign redirect_pc    = redirect_pc_q;

    assign btb_wr_valid  = !empty;
    assign btb_wr_pc     = head[PC_OFS +: XLEN];
    assign btb_wr_target = head[TARGET_OFS +: XLEN];
    assign btb_wr_taken  = head[TAKEN_OFS];

`ifdef BRANCH_PERF_EN
    logic [31:0] perf_br_q, perf_mp_q, perf_st_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
            perf_st_q <= '0;
        end else begin
            if (push)                   perf_br_q <= perf_br_q + 32'd1;
            if (accept && ex_modify_pc) perf_mp_q <= perf_mp_q + 32'd1;
            if (stall_out)              perf_st_q <= perf_st_q + 32'd1;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;
    assign perf_q_stalls    = perf_st_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed plus randomized bench for branch_redirect_ctrl against a
// queue-based reference model.
module tb_branch_redirect_ctrl;
    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_update_btb, ex_modify_pc, ex_predicted_taken;
    logic [31:0] ex_pc, ex_update_pc, ex_jump_addr;
    logic        stall_in, btb_wr_ready;
    logic        redirect_valid, flush_if_id, flush_id_ex, stall_out;
    logic [31:0] redirect_pc, btb_wr_pc, btb_wr_target;
    logic        btb_wr_valid, btb_wr_taken;
`ifdef BRANCH_PERF_EN
    logic [31:0] perf_branches, perf_mispredicts, perf_q_stalls;
`endif

    branch_redirect_ctrl #(.QDEPTH(QD), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_update_btb(ex_update_btb),
        .ex_modify_pc(ex_modify_pc), .ex_predicted_taken(ex_predicted_taken),
        .ex_pc(ex_pc), .ex_update_pc(ex_update_pc), .ex_jump_addr(ex_jump_addr),
        .stall_in(stall_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stall_out(stall_out),
        .btb_wr_valid(btb_wr_valid), .btb_wr_ready(btb_wr_ready),
        .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target),
        .btb_wr_taken(btb_wr_taken)
`ifdef BRANCH_PERF_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts),
        .perf_q_stalls(perf_q_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
    } ent_t;

    ent_t        mq[$];
    bit          m_redir;
    logic [31:0] m_rpc;
    int          m_br, m_mp, m_st;
    bit          e_stall, e_pop;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_redir = 0;
        m_rpc   = '0;
        m_br = 0; m_mp = 0; m_st = 0;
    endtask

    task automatic drive(input bit v, input bit upd, input bit mod, input bit pt,
                         input logic [31:0] pc, input logic [31:0] upc,
                         input logic [31:0] ja, input bit stl, input bit rdy);
        ex_valid = v; ex_update_btb = upd; ex_modify_pc = mod; ex_predicted_taken = pt;
        ex_pc = pc; ex_update_pc = upc; ex_jump_addr = ja;
        stall_in = stl; btb_wr_ready = rdy;
    endtask

    task automatic drive_rand();
        drive($urandom_range(9) < 7, $urandom_range(9) < 6, $urandom_range(9) < 3,
              1'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(9) < 2, 1'($urandom));
    endtask

    // Compare current-cycle outputs with model, away from the clock edge.
    task automatic sample();
        bit vld;
        @(negedge clk);
        vld     = (mq.size() != 0);
        e_pop   = vld && btb_wr_ready;
        e_stall = (mq.size() == QD) && !e_pop && ex_valid && ex_update_btb && !m_redir;
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir});
        chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, m_redir});
        chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, m_redir});
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("stall_out", {31'd0, stall_out}, {31'd0, e_stall});
        chk("btb_wr_valid", {31'd0, btb_wr_valid}, {31'd0, vld});
        if (vld) begin
            chk("btb_wr_pc", btb_wr_pc, mq[0].pc);
            chk("btb_wr_target", btb_wr_target, mq[0].tgt);
            chk("btb_wr_taken", {31'd0, btb_wr_taken}, {31'd0, mq[0].tk});
        end
`ifdef BRANCH_PERF_EN
        chk("perf_branches", perf_branches, m_br);
        chk("perf_mispredicts", perf_mispredicts, m_mp);
        chk("perf_q_stalls", perf_q_stalls, m_st);
`endif
    endtask

    task automatic edge_step();
        bit acc;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            acc = ex_valid && !m_redir && !stall_in && !e_stall;
            if (e_stall) m_st++;
            if (e_pop) void'(mq.pop_front());
            if (acc && ex_update_btb) begin
                e.pc = ex_pc; e.tgt = ex_jump_addr; e.tk = ex_modify_pc ^ ex_predicted_taken;
                mq.push_back(e);
                m_br++;
            end
            if (m_redir) m_redir = 0;
            else if (acc && ex_modify_pc) begin
                m_redir = 1;
                m_rpc   = ex_update_pc;
                m_mp++;
            end
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, rdy);
    endtask

    initial begin
        // Reset for two cycles with a garbage EX stream.
        rst = 1'b1;
        drive_rand();
        model_reset();
        edge_step();
        drive_rand();
        sample();
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_btb_wr_valid", {31'd0, btb_wr_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_btb_wr_pc", btb_wr_pc, 32'd0);
        chk("rst_stall_out", {31'd0, stall_out}, 32'd0);
        edge_step();
        rst = 1'b0;

        // Correctly predicted taken BEQ.
        drive(1, 1, 0, 1, 32'h100, 32'h140, 32'h140, 0, 1);
        sample();
        chk("beq_no_redirect_now", {31'd0, btb_wr_valid}, 32'd0);
        edge_step();
        idle(1);
        sample();
        chk("beq_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("beq_wr_valid", {31'd0, btb_wr_valid}, 32'd1);
        chk("beq_wr_pc", btb_wr_pc, 32'h100);
        chk("beq_wr_target", btb_wr_target, 32'h140);
        chk("beq_wr_taken", {31'd0, btb_wr_taken}, 32'd1);
        edge_step();

        // Mispredict, then a wrong-path mispredict that must be ignored.
        drive(1, 1, 1, 0, 32'h200, 32'h204, 32'h260, 0, 1);
        sample();
        edge_step();
        drive(1, 1, 1, 0, 32'h204, 32'h999, 32'h999, 0, 1);
        sample();
        chk("mp_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("mp_redirect_pc", redirect_pc, 32'h204);
        chk("mp_flush_if_id", {31'd0, flush_if_id}, 32'd1);
        chk("mp_flush_id_ex", {31'd0, flush_id_ex}, 32'd1);
        edge_step();
        idle(1);
        sample();
        chk("mp_one_cycle", {31'd0, redirect_valid}, 32'd0);
        chk("mp_pc_held", redirect_pc, 32'h204);
        edge_step();

        // Fill the queue with ready low, then present a fifth branch.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 32'h300 + 32'(i * 4), 32'h0, 32'h400 + 32'(i), 0, 0);
            sample();
            edge_step();
        end
        drive(1, 1, 0, 0, 32'h310, 32'h0, 32'h404, 0, 0);
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("full_stall", {31'd0, stall_out}, 32'd1);
            edge_step();
        end
        btb_wr_ready = 1'b1;
        sample();
        chk("full_release", {31'd0, stall_out}, 32'd0);
        chk("full_head_pc", btb_wr_pc, 32'h300);
        edge_step();
        idle(1);
        for (int i = 1; i < 5; i++) begin
            sample();
            chk("drain_pc", btb_wr_pc, 32'h300 + 32'(i * 4));
            edge_step();
        end
        sample();
        chk("drain_empty", {31'd0, btb_wr_valid}, 32'd0);
        edge_step();

        // Mispredicting jump held by stall_in.
        drive(1, 0, 1, 0, 32'h500, 32'h580, 32'h580, 1, 1);
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("stall_no_redirect", {31'd0, redirect_valid}, 32'd0);
            edge_step();
        end
        stall_in = 1'b0;
        sample();
        edge_step();
        idle(1);
        sample();
        chk("stall_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("stall_redirect_pc", redirect_pc, 32'h580);
        edge_step();
        sample();
        chk("stall_single", {31'd0, redirect_valid}, 32'd0);
`ifdef BRANCH_PERF_EN
        chk("perf_br_const", perf_branches, 32'd7);
        chk("perf_mp_const", perf_mispredicts, 32'd2);
        chk("perf_st_const", perf_q_stalls, 32'd2);
`endif
        edge_step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            drive_rand();
            rst = ($urandom_range(99) == 0);
            sample();
            edge_step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
